// File: rtl/edge_cnt_pkg.sv
// Shared constants and types for the edge event counter: default counter
// geometry and the snapshot handshake state encoding.
package edge_cnt_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_WRAP  = 7;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_e;

endpackage : edge_cnt_pkg

// File: rtl/edge_sync.sv
// Two-flop synchronizer for the asynchronous event line followed by a
// "previous" flop; emits single-cycle rise/fall pulses from the synced level.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q;
  logic sync1_d, sync2_d, prev_d;

  assign sync1_d = d_i;
  assign sync2_d = sync1_q;
  assign prev_d  = sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Only one of these can be high at a time since they need opposite levels.
  assign rise_o = sync2_q & ~prev_q;
  assign fall_o = ~sync2_q & prev_q;

endmodule : edge_sync

// File: rtl/edge_event_counter.sv
// Counts rising and falling edges of an asynchronous line with wrapping
// counters, a sticky overflow flag and a valid/ready snapshot of the total.
module edge_event_counter
  import edge_cnt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int WRAP  = DEFAULT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             clr,
  output logic [WIDTH-1:0] pos_count,
  output logic [WIDTH-1:0] neg_count,
  output logic [WIDTH:0]   total_count,
  output logic             ovf,
  input  logic             snap_req,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic [WIDTH:0]   snap_data
);

  localparam logic [WIDTH-1:0] WRAP_V = WIDTH'(WRAP);

  logic rise, fall;

  edge_sync u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (d),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Index 0 counts rises, index 1 counts falls.
  logic [1:0]         evt;
  logic [1:0]         wrap_hit;
  logic [2*WIDTH-1:0] cnt_flat;

  assign evt = {fall, rise};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             hit;

    always_comb begin
      cnt_d = cnt_q;
      hit   = 1'b0;
      if (evt[gi]) begin
        if (cnt_q == WRAP_V) begin
          cnt_d = '0;
          hit   = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
    end

    // clr drops any coincident edge by overriding the increment.
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_flat[gi*WIDTH +: WIDTH] = cnt_q;
    assign wrap_hit[gi]                = hit;
  end

  assign pos_count   = cnt_flat[0 +: WIDTH];
  assign neg_count   = cnt_flat[WIDTH +: WIDTH];
  assign total_count = {1'b0, pos_count} + {1'b0, neg_count};

  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (|wrap_hit) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;

  snap_state_e      state_q, state_d;
  logic [WIDTH:0]   snap_data_q, snap_data_d;

  always_comb begin
    state_d     = state_q;
    snap_data_d = snap_data_q;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          state_d     = HOLD;
          snap_data_d = total_count;
        end
      end
      HOLD: begin
        // A coincident snap_req only completes the handshake.
        if (snap_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      snap_data_q <= '0;
    end else begin
      state_q     <= state_d;
      snap_data_q <= snap_data_d;
    end
  end

  assign snap_valid = (state_q == HOLD);
  assign snap_data  = snap_data_q;

endmodule : edge_event_counter

// File: doc/edge_event_counter.md
EDGE_EVENT_COUNTER -- requirements
Module: edge_event_counter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each per-edge counter.
REQ-002 Parameter WRAP, default 7: last count value before a per-edge counter returns to 0.
REQ-003 clk  input  1: single clock; all logic on rising edge.
REQ-004 rst  input  1: reset is synchronous and active-high.
REQ-005 d  input  1: asynchronous event line whose rising and falling edges are counted.
REQ-006 clr  input  1: synchronous clear of counters and overflow flag.
REQ-007 pos_count  output  WIDTH: number of rising edges of d, modulo WRAP+1.
REQ-008 neg_count  output  WIDTH: number of falling edges of d, modulo WRAP+1.
REQ-009 total_count  output  WIDTH+1: pos_count + neg_count, zero-extended, no truncation.
REQ-010 ovf  output  1: sticky flag, set when either counter wraps.
REQ-011 snap_req  input  1: request a snapshot of total_count.
REQ-012 snap_valid  output  1: snapshot data valid.
REQ-013 snap_ready  input  1: consumer accepts the snapshot.
REQ-014 snap_data  output  WIDTH+1: captured total_count.

Function
REQ-015 d SHALL pass through a 2-flop synchronizer, then a third "previous" flop; rise = sync & ~prev, fall = ~sync & prev.
REQ-016 A d transition first sampled at rising edge k SHALL update pos_count/neg_count at rising edge k+2 (3-edge latency).
REQ-017 On rise, pos_count SHALL increment; when pos_count equals WRAP it SHALL load 0 instead.
REQ-018 On fall, neg_count SHALL behave identically to REQ-017.
REQ-019 rise and fall SHALL be mutually exclusive in any cycle; no simultaneous update case exists.
REQ-020 ovf SHALL set on the edge where either counter goes from WRAP to 0, and hold until clr or rst.
REQ-021 clr SHALL zero pos_count, neg_count, and ovf on the next edge; clr wins over a coincident rise/fall, which is dropped.
REQ-022 clr SHALL NOT flush the synchronizer flops and SHALL NOT affect the snapshot FSM.
REQ-023 total_count SHALL be combinational from the counter registers; maximum value 2*WRAP.
REQ-024 The snapshot FSM SHALL have states IDLE and HOLD; reset state IDLE.
REQ-025 IDLE with snap_req=1: capture the current registered total_count into snap_data, go to HOLD; snap_valid=1 from the next cycle.
REQ-026 HOLD: snap_valid=1 and snap_data stable; snap_ready=1 returns the FSM to IDLE and deasserts snap_valid next cycle.
REQ-027 snap_req during HOLD SHALL be ignored; a new capture requires a return to IDLE first.
REQ-028 snap_req and snap_ready together in HOLD SHALL complete the handshake only; no back-to-back capture.

Reset
REQ-029 rst SHALL clear the synchronizer flops, pos_count, neg_count, ovf, and snap_data to 0, clear snap_valid, and set the FSM to IDLE on the next edge.
REQ-030 rst SHALL take precedence over clr, snap_req, snap_ready, and detected edges; rst mid-HOLD SHALL drop the pending snapshot.
REQ-031 d=1 held through reset SHALL count one rise in the 3-edge window after rst deasserts.

Structure
REQ-032 Package edge_cnt_pkg SHALL hold the default WIDTH/WRAP constants and the snapshot state enum {IDLE, HOLD}.
REQ-033 Sub-module edge_sync (synchronizer, previous flop, rise/fall pulses) SHALL be instantiated once.
REQ-034 All remaining logic SHALL reside in edge_event_counter; no latches, no second clock domain.

Verification
REQ-035 rst held 2 cycles with d=0, then released -> all outputs 0, snap_valid=0.
REQ-036 Toggle d 0->1->0, each level held 4 cycles -> pos_count=1 exactly 3 edges after the first sample, then neg_count=1, total_count=2.
REQ-037 Apply 8 full d pulses -> pos_count and neg_count wrap 7->0, ovf=1 and stays 1, total_count=0.
REQ-038 Assert clr in the same cycle a rise is detected -> pos_count=0 afterward, the rise is not counted, ovf=0.
REQ-039 With total_count=5, pulse snap_req, then change counts and hold snap_ready=0 for 5 cycles -> snap_valid=1 with snap_data=5 stable throughout; snap_ready=1 -> snap_valid=0 next cycle.
REQ-040 Assert rst while in HOLD -> snap_valid=0, snap_data=0, and the FSM in IDLE on the next edge.
